// File: rtl/song_pkg.sv
//------------------------------------------------------------------------------
// Module      : song_pkg
// Description : Shared state encoding and ROM field layout for song_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package song_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        PLAY  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PERIOD_MSB = 11;
    localparam int PERIOD_LSB = 4;
    localparam int BEATS_MSB  = 3;
    localparam int BEATS_LSB  = 0;

    localparam int PERIOD_W = PERIOD_MSB - PERIOD_LSB + 1;
    localparam int BEATS_W  = BEATS_MSB - BEATS_LSB + 1;
    localparam int ROM_W    = PERIOD_W + BEATS_W;

    localparam logic [BEATS_W-1:0] END_BEATS = '0;

    function automatic logic [PERIOD_W-1:0] get_period(input logic [ROM_W-1:0] word);
        return word[PERIOD_MSB:PERIOD_LSB];
    endfunction

    function automatic logic [BEATS_W-1:0] get_beats(input logic [ROM_W-1:0] word);
        return word[BEATS_MSB:BEATS_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/beat_timer.sv
//------------------------------------------------------------------------------
// Module      : beat_timer
// Description : Counts beats*BEAT_CYCLES enabled cycles after a load; flags the last one.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module beat_timer
    import song_pkg::*;
#(
    parameter int BEAT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BEATS_W-1:0] beats,
    input  logic               en,
    output logic               last
);

    localparam int               c_cyc_w      = $clog2(BEAT_CYCLES);
    localparam logic [c_cyc_w-1:0] c_cyc_reload = c_cyc_w'(BEAT_CYCLES - 1);

    logic [c_cyc_w-1:0] r_cyc;
    logic [BEATS_W-1:0] r_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc  <= '0;
            r_beat <= '0;
        end else if (load) begin
            r_cyc  <= c_cyc_reload;
            r_beat <= beats;
        end else if (en) begin
            if (r_cyc == '0) begin
                r_cyc  <= c_cyc_reload;
                r_beat <= r_beat - BEATS_W'(1);
            end else begin
                r_cyc <= r_cyc - c_cyc_w'(1);
            end
        end
    end

    // r_beat holds the beats still to play including the current one.
    assign last = en && (r_cyc == '0) && (r_beat == BEATS_W'(1));

endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
//------------------------------------------------------------------------------
// Module      : song_sequencer
// Description : Walks a song ROM of {period, beats} entries and drives a note player.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module song_sequencer
    import song_pkg::*;
#(
    parameter int BEAT_CYCLES = 16,
    parameter int GAP_CYCLES  = 1,
    parameter int ADDR_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [ROM_W-1:0]    rom_data,
    output logic                player_rst,
    output logic [PERIOD_W-1:0] player_period,
    output logic                busy,
    output logic                done
);

    localparam int                 c_gap_w      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_reload = c_gap_w'(GAP_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [PERIOD_W-1:0] r_period;
    logic [c_gap_w-1:0]  r_gap;

    logic w_end;
    logic w_abort;
    logic w_load;
    logic w_play;
    logic w_last;

    assign w_end   = (get_beats(rom_data) == END_BEATS);
    assign w_abort = stop && (r_state != IDLE);
    assign w_load  = (r_state == FETCH) && !w_end;
    assign w_play  = (r_state == PLAY);

    beat_timer #(
        .BEAT_CYCLES (BEAT_CYCLES)
    ) u_beat_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .beats (get_beats(rom_data)),
        .en    (w_play),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != IDLE);
        done          = 1'b0;
        player_rst    = 1'b1;
        player_period = '0;

        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                player_period = r_period;
                if (w_end) begin
                    w_next = loop ? FETCH : DONE;
                end else begin
                    w_next = PLAY;
                end
            end
            PLAY: begin
                player_period = r_period;
                player_rst    = (r_period == '0);
                if (w_last) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                // Holding the player in reset here restarts every note cleanly.
                player_period = r_period;
                if (r_gap == '0) begin
                    w_next = FETCH;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        if (w_abort) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_period <= '0;
            r_gap    <= '0;
        end else if (w_abort) begin
            r_addr <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_end) begin
                        if (loop) begin
                            r_addr <= '0;
                        end
                    end else begin
                        r_period <= get_period(rom_data);
                    end
                end
                PLAY: begin
                    if (w_last) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_gap  <= c_gap_reload;
                    end
                end
                GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - c_gap_w'(1);
                    end
                end
                DONE: begin
                    r_addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_song_sequencer
// Description : Directed scenarios plus randomized traffic against a per-note timeline model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_song_sequencer;

    localparam int BC    = 4;
    localparam int GC    = 1;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic          player_rst;
    logic [7:0]    player_period;
    logic          busy;
    logic          done;

    logic [7:0] rom_period [DEPTH];
    logic [3:0] rom_beats  [DEPTH];

    assign rom_data = {rom_period[rom_addr], rom_beats[rom_addr]};

    song_sequencer #(
        .BEAT_CYCLES (BC),
        .GAP_CYCLES  (GC),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .loop          (loop),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .player_rst    (player_rst),
        .player_period (player_period),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the song is unrolled into a queue of per-cycle expected outputs.
    typedef struct {
        bit         busy;
        bit         done;
        bit         prst;
        bit         chk_prst;
        logic [7:0] period;
        bit         chk_period;
        int         addr;
        bit         end_fetch;
    } exp_t;

    exp_t q[$];
    bit   running   = 0;
    int   next_addr = 0;

    function automatic exp_t mk(bit b, bit d, bit p, bit cp, logic [7:0] per, bit cper, int a, bit ef);
        exp_t e;
        e.busy = b; e.done = d; e.prst = p; e.chk_prst = cp;
        e.period = per; e.chk_period = cper; e.addr = a; e.end_fetch = ef;
        return e;
    endfunction

    task automatic expand(input int a);
        int n;
        if (rom_beats[a] == 4'd0) begin
            q.push_back(mk(1, 0, 1, 0, 8'd0, 0, a, 1));
        end else begin
            q.push_back(mk(1, 0, 1, 0, 8'd0, 0, a, 0));
            n = int'(rom_beats[a]) * BC;
            for (int i = 0; i < n; i++)
                q.push_back(mk(1, 0, rom_period[a] == 8'd0, 1, rom_period[a], 1, a, 0));
            for (int i = 0; i < GC; i++)
                q.push_back(mk(1, 0, 1, 1, rom_period[a], 1, (a + 1) % DEPTH, 0));
            next_addr = (a + 1) % DEPTH;
        end
    endtask

    always @(posedge clk) begin
        exp_t cur;
        bit   was_busy;
        was_busy = (q.size() > 0);
        cur = mk(0, 0, 1, 1, 8'd0, 1, 0, 0);
        if (was_busy) cur = q.pop_front();
        if (rst) begin
            q.delete();
            running = 0;
        end else if (was_busy && stop) begin
            q.delete();
            running = 0;
        end else if (!was_busy) begin
            if (start && !stop) begin
                running   = 1;
                next_addr = 0;
            end
        end else if (cur.end_fetch) begin
            if (loop) begin
                next_addr = 0;
            end else begin
                q.push_back(mk(1, 1, 1, 1, 8'd0, 0, cur.addr, 0));
                running = 0;
            end
        end
        if (running && q.size() == 0) expand(next_addr);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) e = q[0];
        else              e = mk(0, 0, 1, 1, 8'd0, 1, 0, 0);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("rom_addr", rom_addr, e.addr);
        if (e.chk_prst)   chk("player_rst", player_rst, e.prst);
        if (e.chk_period) chk("player_period", player_period, e.period);
    end

    task automatic load_rom(input logic [7:0] p0, input logic [3:0] b0, input logic [7:0] p1,
                            input logic [3:0] b1, input logic [7:0] p2, input logic [3:0] b2,
                            input logic [7:0] p3, input logic [3:0] b3);
        rom_period[0] = p0; rom_beats[0] = b0;
        rom_period[1] = p1; rom_beats[1] = b1;
        rom_period[2] = p2; rom_beats[2] = b2;
        rom_period[3] = p3; rom_beats[3] = b3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_and_check(input string name);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk(name, busy, 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget && busy; k++) @(negedge clk);
        chk(name, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd, di, n10, n20, nrel, last_a;
        int seq[$];

        load_rom(8'h10, 4'd2, 8'h20, 4'd1, 8'h00, 4'd0, 8'h33, 4'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_player_rst", player_rst, 1);
        chk("reset_period", player_period, 0);
        chk("reset_addr", rom_addr, 0);

        // Two-note song; a start pulse in mid-play must not disturb it.
        pulse_start();
        nb = 0; nd = 0; di = -1; n10 = 0; n20 = 0;
        for (int k = 0; k < 100 && busy; k++) begin
            nb++;
            if (done) begin nd++; di = nb; end
            if (!player_rst && player_period == 8'h10) n10++;
            if (!player_rst && player_period == 8'h20) n20++;
            start = (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("song1_busy_cycles", nb, 18);
        chk("song1_done_count", nd, 1);
        chk("song1_done_pos", di, 18);
        chk("song1_note1_cycles", n10, 8);
        chk("song1_note2_cycles", n20, 4);
        chk("song1_idle", busy, 0);

        // start together with stop in IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", busy, 0);
        @(negedge clk);
        chk("start_stop_idle2", busy, 0);

        // Rest entry keeps the player in reset while the address still advances.
        load_rom(8'h00, 4'd1, 8'h40, 4'd1, 8'h00, 4'd0, 8'h00, 4'd0);
        pulse_start();
        nb = 0; nrel = 0;
        for (int k = 0; k < 100 && busy; k++) begin
            nb++;
            if (!player_rst) nrel++;
            @(negedge clk);
        end
        chk("rest_busy_cycles", nb, 14);
        chk("rest_released_cycles", nrel, 4);
        chk("rest_idle", busy, 0);

        // Looping song never completes until stopped.
        load_rom(8'h08, 4'd1, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd0);
        loop = 1'b1;
        pulse_start();
        nd = 0; last_a = -1; seq.delete();
        for (int k = 0; k < 40; k++) begin
            if (int'(rom_addr) != last_a) seq.push_back(int'(rom_addr));
            last_a = int'(rom_addr);
            if (done) nd++;
            @(negedge clk);
        end
        chk("loop_no_done", nd, 0);
        for (int i = 0; i < 4; i++)
            chk("loop_addr_seq", (i < seq.size()) ? seq[i] : -1, i % 2);
        chk("loop_still_busy", busy, 1);
        stop_and_check("loop_stop");
        loop = 1'b0;

        // Reset on the third PLAY cycle abandons the note.
        load_rom(8'h10, 4'd2, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd0);
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_player_rst", player_rst, 1);
        chk("midrst_done", done, 0);
        pulse_start();
        chk("midrst_restart_busy", busy, 1);
        chk("midrst_restart_addr", rom_addr, 0);
        wait_idle("midrst_finish", 100);

        // No end marker: the address wraps 3 -> 0 and playback continues.
        load_rom(8'h01, 4'd1, 8'h02, 4'd1, 8'h03, 4'd1, 8'h04, 4'd1);
        pulse_start();
        last_a = -1; seq.delete();
        for (int k = 0; k < 40; k++) begin
            if (int'(rom_addr) != last_a) seq.push_back(int'(rom_addr));
            last_a = int'(rom_addr);
            @(negedge clk);
        end
        chk("wrap_addr3", (seq.size() > 3) ? seq[3] : -1, 3);
        chk("wrap_addr0", (seq.size() > 4) ? seq[4] : -1, 0);
        chk("wrap_busy", busy, 1);
        stop_and_check("wrap_stop");

        // Randomized traffic over random songs.
        for (int r = 0; r < 30; r++) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rom_beats[i]  = 4'($urandom_range(0, 3));
                rom_period[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            for (int c = 0; c < 150; c++) begin
                start = ($urandom_range(0, 7) == 0);
                stop  = ($urandom_range(0, 39) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                loop  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            start = 1'b0; stop = 1'b0; rst = 1'b0; loop = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 The block SHALL have parameter BEAT_CYCLES, default 16, giving clk cycles per beat (>=2).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving inter-note silence cycles (>=1).
REQ-003 The block SHALL have parameter ADDR_W, default 5, giving the song ROM address width.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a one-cycle pulse that begins playback from address 0.
REQ-007 The block SHALL have port stop, input, 1, which aborts playback.
REQ-008 The block SHALL have port loop, input, 1, which restarts at address 0 on reaching the end marker.
REQ-009 The block SHALL have port rom_addr, output, ADDR_W, the song ROM read address.
REQ-010 The block SHALL have port rom_data, input, 12, the combinational ROM data {period[11:4], beats[3:0]}, valid in the same cycle as rom_addr.
REQ-011 The block SHALL have port player_rst, output, 1, which drives the rst input of the downstream note player.
REQ-012 The block SHALL have port player_period, output, 8, which drives the period input of the note player.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse on normal song completion.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, FETCH, PLAY, GAP and DONE.
REQ-016 IDLE behaviour: player_rst=1, player_period=0, rom_addr=0, busy=0; start -> FETCH on the next cycle.
REQ-017 FETCH behaviour (exactly 1 cycle): beats==0 is the end marker; the state then goes to FETCH with rom_addr=0 if loop=1, else to DONE; otherwise period and beats are latched and the state goes to PLAY.
REQ-018 PLAY SHALL last exactly beats*BEAT_CYCLES cycles, using a cycle counter that reloads BEAT_CYCLES-1 and a beat counter loaded from the latched beats.
REQ-019 PLAY outputs: player_period=latched period; player_rst=0, except player_rst=1 when the latched period==0 (rest).
REQ-020 On the last PLAY cycle, rom_addr SHALL increment, wrapping from 2^ADDR_W-1 to 0, and the state SHALL go to GAP.
REQ-021 GAP SHALL last GAP_CYCLES cycles with player_rst=1 and player_period held, so that each note restarts the note player from LOAD_HIGH; then -> FETCH.
REQ-022 DONE SHALL last 1 cycle with done=1, busy=1 and player_rst=1; then -> IDLE.
REQ-023 stop=1 in any non-IDLE state SHALL force IDLE on the next cycle with no done pulse; stop has priority over all other transitions.
REQ-024 start SHALL be ignored while busy=1, and start and stop asserted together in IDLE SHALL leave the block in IDLE.
REQ-025 loop SHALL be sampled only in a FETCH cycle that reads an end marker.
REQ-026 Per-entry timing SHALL be 1 FETCH cycle + beats*BEAT_CYCLES PLAY cycles + GAP_CYCLES GAP cycles.
REQ-027 A song with 2^ADDR_W entries and no end marker SHALL wrap and continue playing until stop.

Reset
REQ-028 rst SHALL act synchronously on the rising clk edge; all registers are cleared and the state becomes IDLE.
REQ-029 Output values after reset SHALL be: player_rst=1, player_period=0, rom_addr=0, busy=0, done=0.
REQ-030 Reset asserted mid-PLAY SHALL abandon the note with no done pulse; the block SHALL then accept start normally.

Structure
REQ-031 Package song_pkg SHALL hold the state enum, the ROM field slice constants (PERIOD_MSB/LSB, BEATS_MSB/LSB) and END_BEATS=0.
REQ-032 One sub-module, beat_timer, SHALL contain the cycle and beat counters, with inputs load, beats and en and output last; the FSM stays in song_sequencer.

Verification (BEAT_CYCLES=4, GAP_CYCLES=1)
REQ-033 Scenario ROM {0x10,2},{0x20,1},{0,0} with start -> FETCH, 8 PLAY cycles at period 0x10, GAP, FETCH, 4 PLAY cycles at period 0x20, GAP, FETCH, then DONE with done high for 1 cycle, then IDLE.
REQ-034 Scenario rest entry {0x00,1} -> player_rst=1 for all 4 PLAY cycles, and rom_addr advances normally.
REQ-035 Scenario loop=1 with ROM {0x08,1},{0,0} -> rom_addr sequence 0,1,0,1,... and no done pulse; stop -> IDLE the next cycle.
REQ-036 Scenario rst pulsed on the 3rd PLAY cycle -> next cycle state IDLE, player_rst=1, busy=0; a following start replays from address 0.
REQ-037 Scenario ADDR_W=2 with a ROM that has no end marker -> rom_addr goes 3 then 0 and playback continues.
REQ-038 Scenario start pulsed during PLAY, and start with stop together in IDLE -> no state change in either case.
